rr_arbiter_tree: RTL and testbench
==================================

// Module: rr_arbiter_tree
// PURPOSE
// - Round-robin arbiter for NumIn req/gnt input streams onto one output stream; forwards winner's data and index.
// - Combinational req->gnt and data path. Only the priority pointer and lock state are registered.
// - Sits in front of shared resources (interconnect ports, shared buses). Inputs are valid/ready-style streams.
// PARAMETERS
// - NumIn      default 64  number of input streams, >=1.
// - DataWidth  default 32  payload width per stream.
// - ExtPrio    default 0   1: priority pointer is taken from rr_i; 0: internal pointer is used.
// - AxiVldRdy  default 0   1: gnt_o[i] may assert without req_i[i] (AXI ready); 0: gnt_o[i] requires req_i[i].
// - LockIn     default 0   1: hold arbitration decision while req_o && !gnt_i.
// - FairArb    default 1   1: fair round-robin over active requesters; 0: pointer simply cycles 0..NumIn-1.
// - IdxWidth   derived     NumIn>1 ? $clog2(NumIn) : 1.
// PORTS
// - clk      in   1                   clock; all registers sample on rising edge.
// - rst_n    in   1                   reset, asynchronous, active-high.
// - flush_i  in   1                   synchronous clear of pointer and lock state.
// - rr_i     in   IdxWidth            external priority pointer; used only if ExtPrio=1.
// - req_i    in   NumIn               per-input request (valid).
// - gnt_o    out  NumIn               per-input grant (ready).
// - data_i   in   NumIn x DataWidth   per-input payload, packed [NumIn-1:0][DataWidth-1:0].
// - req_o    out  1                   output request (valid).
// - gnt_i    in   1                   output grant (ready).
// - data_o   out  DataWidth           payload of selected input.
// - idx_o    out  IdxWidth            index of selected input.
// BEHAVIOUR
// - Registers: rr_q (IdxWidth), lock_q (1), req_q (NumIn). All reset to 0 under rst_n. flush_i clears all three on the next edge.
// - Effective request vector: req_eff = (LockIn && lock_q) ? req_q : req_i.
// - req_o = |req_eff.
// - idx_o is the selected index; data_o = data_i[idx_o].
// - With req_eff=0: req_o=0, idx_o=0 and data_o=data_i[0] (don't-care to consumer).
// - gnt_o[k] = gnt_i && (idx_o==k) && (AxiVldRdy || req_i[k]). At most one gnt_o bit is high per cycle.
// - Transfer on an input occurs when req_i[k] && gnt_o[k]. Output transfer occurs when req_o && gnt_i.
// - Selection with FairArb=1: winner is the lowest requesting index strictly above the pointer. If none exists, it is the lowest requesting index overall (wrap-around).
// - Selection with FairArb=0: tree of 2:1 nodes; each node favours the child selected by the pointer bit for that level, else the other requester.
// - Pointer source: ExtPrio=1 uses rr_i, and rr_q is not used.
// - Pointer update with ExtPrio=0, only on an output transfer:
//     FairArb=1 -> rr_q <= idx_o.
//     FairArb=0 -> rr_q <= (rr_q==NumIn-1) ? 0 : rr_q+1.
// - Lock when LockIn=1:
//     lock_q <= req_o && !gnt_i; req_q <= req_eff whenever lock_q would be set.
//     While locked, the same idx_o/data_o are presented until gnt_i. flush_i breaks the lock.
// - Inputs must not drop req_i or change data_i before their grant; a requester dropping while locked is a protocol error.
// - Fairness: with j continuously active requesters and gnt_i=1, each requester is served 1/j of cycles (+-0.1).
// - NumIn=1: pass-through; idx_o=0; gnt_o[0] = gnt_i && (AxiVldRdy || req_i[0]).
// - Reset mid-transfer: pointer returns to 0 and lock is dropped; combinational outputs follow the inputs immediately.
// STRUCTURE
// - Package rr_arbiter_pkg: idx-width function, idx_t typedef.
// - Sub-module arb_lzc: trailing-zero/first-one finder (NumIn wide, returns index and empty flag). Used twice for the masked and unmasked search in fair mode.
// - Top level: pointer/lock registers and the gnt/data mux.
// TESTING
// - Single input 3 constantly requesting, gnt_i=1 -> gnt_o=8'b0000_1000 every cycle, idx_o=3, data_o=data_i[3].
// - Inputs 0,2,5 requesting, gnt_i=1, FairArb=1 -> grant sequence 0,2,5,0,2,5...; each served 1/3 of cycles.
// - LockIn=1: req on 1 and 4, gnt_i=0 for 3 cycles, then input 6 raises req -> idx_o stays at the first winner until gnt_i=1.
// - flush_i pulse while locked and rr_q=5 -> next cycle lock_q=0 and rr_q=0; selection restarts from index 1.
// - AxiVldRdy=0, req_i=0, gnt_i=1 -> gnt_o=0, req_o=0. AxiVldRdy=1, same inputs -> gnt_o equals one-hot of idx_o.
// - Random data, NumIn=7, DataWidth=45: scoreboard per-input queues; every output transfer's data_o matches the queue front for idx_o.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
// Debug state is widened to a fixed size so one struct type serves every instance.
package rr_arbiter_pkg;

  localparam int MaxIdxWidth = 16;

  typedef logic [MaxIdxWidth-1:0] idx_t;

  typedef struct packed {
    logic lock;
    idx_t rr;
  } arb_dbg_t;

  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_tree_if.sv
// Request/grant bundle between NumIn input streams, the arbiter and one output stream.
// Also carries the arbiter's registered pointer/lock state for observation.
interface rr_arbiter_tree_if #(
  parameter int NumIn     = 64,
  parameter int DataWidth = 32
) ();
  import rr_arbiter_pkg::*;

  localparam int IdxWidth = idx_width(NumIn);

  // Valid/ready: an input beat moves when req_i[k] && gnt_o[k], the output beat
  // when req_o && gnt_i; a raised request keeps its data stable until accepted.
  logic [NumIn-1:0]                req_i;
  logic [NumIn-1:0]                gnt_o;
  logic [NumIn-1:0][DataWidth-1:0] data_i;
  logic                            req_o;
  logic                            gnt_i;
  logic [DataWidth-1:0]            data_o;
  logic [IdxWidth-1:0]             idx_o;
  arb_dbg_t                        dbg;

  modport master (
    input  req_i, data_i, gnt_i,
    output gnt_o, req_o, data_o, idx_o, dbg
  );

  modport slave (
    output req_i, data_i, gnt_i,
    input  gnt_o, req_o, data_o, idx_o, dbg
  );

endinterface

// File: rtl/rr_arbiter_tree_lzc.sv
// First-one finder: index of the lowest set bit and an all-zero flag.
// Index is 0 when the vector is empty.
module arb_lzc
  import rr_arbiter_pkg::*;
#(
  parameter int Width = 8,
  parameter int IdxW  = idx_width(Width)
) (
  input  logic [Width-1:0] in_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             empty_o
);

  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) idx_o = IdxW'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/rr_arbiter_tree.sv
// Round-robin arbiter: NumIn req/gnt streams onto one output, combinational select,
// registered priority pointer and optional decision lock while the output stalls.
module rr_arbiter_tree
  import rr_arbiter_pkg::*;
#(
  parameter int NumIn     = 64,
  parameter int DataWidth = 32,
  parameter bit ExtPrio   = 1'b0,
  parameter bit AxiVldRdy = 1'b0,
  parameter bit LockIn    = 1'b0,
  parameter bit FairArb   = 1'b1,
  localparam int IdxWidth = idx_width(NumIn)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic [IdxWidth-1:0] rr_i,
  rr_arbiter_tree_if.master   bus
);

  localparam int NumPad = 1 << IdxWidth;

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic                lock_q, lock_d;
  logic [NumIn-1:0]    req_q, req_d;

  logic [NumIn-1:0]    req_eff, prio_mask, req_masked;
  logic [IdxWidth-1:0] ptr, masked_idx, any_idx, fair_idx, tree_idx, sel_idx;
  logic                masked_empty, any_empty, out_valid, xfer;

  // A locked decision replays the request set captured when the stall began.
  assign req_eff = (LockIn && lock_q) ? req_q : bus.req_i;
  assign ptr     = ExtPrio ? rr_i : rr_q;

  always_comb begin
    prio_mask = '0;
    for (int k = 0; k < NumIn; k++) begin
      prio_mask[k] = (IdxWidth'(k) > ptr);
    end
  end

  assign req_masked = req_eff & prio_mask;

  arb_lzc #(.Width(NumIn), .IdxW(IdxWidth)) u_lzc_masked (
    .in_i    (req_masked),
    .idx_o   (masked_idx),
    .empty_o (masked_empty)
  );

  arb_lzc #(.Width(NumIn), .IdxW(IdxWidth)) u_lzc_any (
    .in_i    (req_eff),
    .idx_o   (any_idx),
    .empty_o (any_empty)
  );

  assign fair_idx = masked_empty ? any_idx : masked_idx;

  // Binary tree reduced in place: level lvl merges pairs and is steered by ptr[lvl],
  // so the root decides the index MSB.
  always_comb begin
    logic [NumPad-1:0]   node_v;
    logic [IdxWidth-1:0] node_idx [NumPad];
    logic                take_right;
    node_v     = '0;
    take_right = 1'b0;
    node_v[NumIn-1:0] = req_eff;
    for (int i = 0; i < NumPad; i++) begin
      node_idx[i] = IdxWidth'(i);
    end
    for (int lvl = 0; lvl < IdxWidth; lvl++) begin
      for (int n = 0; n < (NumPad >> (lvl + 1)); n++) begin
        take_right  = node_v[2*n+1] & (ptr[lvl] | ~node_v[2*n]);
        node_idx[n] = take_right ? node_idx[2*n+1] : node_idx[2*n];
        node_v[n]   = node_v[2*n] | node_v[2*n+1];
      end
    end
    tree_idx = node_idx[0];
  end

  assign out_valid = ~any_empty;
  assign sel_idx   = any_empty ? '0 : (FairArb ? fair_idx : tree_idx);
  assign xfer      = out_valid && bus.gnt_i;

  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    req_d  = req_q;
    if (flush_i) begin
      rr_d   = '0;
      lock_d = 1'b0;
      req_d  = '0;
    end else begin
      if (!ExtPrio && xfer) begin
        if (FairArb) rr_d = sel_idx;
        else         rr_d = (rr_q == IdxWidth'(NumIn - 1)) ? '0 : rr_q + IdxWidth'(1);
      end
      lock_d = LockIn && out_valid && !bus.gnt_i;
      if (lock_d) req_d = req_eff;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      req_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      req_q  <= req_d;
    end
  end

  always_comb begin
    bus.gnt_o = '0;
    for (int k = 0; k < NumIn; k++) begin
      bus.gnt_o[k] = bus.gnt_i && (sel_idx == IdxWidth'(k)) && (AxiVldRdy || bus.req_i[k]);
    end
  end

  assign bus.req_o  = out_valid;
  assign bus.idx_o  = sel_idx;
  assign bus.data_o = bus.data_i[sel_idx];
  assign bus.dbg    = '{lock: lock_q, rr: idx_t'(rr_q)};

endmodule

// File: tb/tb_rr_arbiter_tree.sv
// Bench for rr_arbiter_tree: five configurations checked every cycle against a
// rule-level reference model, plus directed scenarios and a data scoreboard.
module tb_rr_arbiter_tree;
  import rr_arbiter_pkg::*;

  localparam int NC  = 7;
  localparam int DWC = 45;

  typedef struct packed {
    logic [31:0] ptr;
    logic        lock;
    logic [63:0] held;
  } mstate_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] rr_a = '0, rr_b = '0, rr_c = '0, rr_x = '0;
  logic       rr_e = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_c_xfer = 0;
  int served_a [8];
  logic [63:0] gnt_a, gnt_b, gnt_c, gnt_d, gnt_e;
  mstate_t st_a, st_b, st_c, st_d, st_e;
  logic [DWC-1:0] exp_q [NC][$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  rr_arbiter_tree_if #(.NumIn(8),  .DataWidth(16))  bus_a ();
  rr_arbiter_tree_if #(.NumIn(8),  .DataWidth(16))  bus_b ();
  rr_arbiter_tree_if #(.NumIn(NC), .DataWidth(DWC)) bus_c ();
  rr_arbiter_tree_if #(.NumIn(5),  .DataWidth(8))   bus_d ();
  rr_arbiter_tree_if #(.NumIn(1),  .DataWidth(8))   bus_e ();

  rr_arbiter_tree #(.NumIn(8), .DataWidth(16), .ExtPrio(1'b0), .AxiVldRdy(1'b0),
                    .LockIn(1'b1), .FairArb(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .rr_i(rr_a), .bus(bus_a));
  rr_arbiter_tree #(.NumIn(8), .DataWidth(16), .ExtPrio(1'b0), .AxiVldRdy(1'b1),
                    .LockIn(1'b0), .FairArb(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .rr_i(rr_b), .bus(bus_b));
  rr_arbiter_tree #(.NumIn(NC), .DataWidth(DWC), .ExtPrio(1'b0), .AxiVldRdy(1'b0),
                    .LockIn(1'b0), .FairArb(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .rr_i(rr_c), .bus(bus_c));
  rr_arbiter_tree #(.NumIn(5), .DataWidth(8), .ExtPrio(1'b1), .AxiVldRdy(1'b0),
                    .LockIn(1'b0), .FairArb(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .rr_i(rr_x), .bus(bus_d));
  rr_arbiter_tree #(.NumIn(1), .DataWidth(8), .ExtPrio(1'b0), .AxiVldRdy(1'b0),
                    .LockIn(1'b1), .FairArb(1'b1)) u_e (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .rr_i(rr_e), .bus(bus_e));

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Fair: scan forward from the slot after the pointer, wrapping around.
  function automatic int fair_pick(input logic [63:0] req, input int ptr, input int n);
    int k;
    for (int s = 1; s <= n; s++) begin
      k = (ptr + s) % n;
      if (req[k]) return k;
    end
    return 0;
  endfunction

  function automatic bit any_in(input logic [63:0] req, input int base, input int len, input int n);
    for (int i = base; i < base + len; i++) begin
      if (i < n && req[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Tree: halve the index range from the top; pointer bit picks the preferred half.
  function automatic int tree_pick(input logic [63:0] req, input int ptr, input int n);
    int w, lo, half, pref, other;
    w  = (n > 1) ? $clog2(n) : 1;
    lo = 0;
    for (int lvl = w - 1; lvl >= 0; lvl--) begin
      half  = 1 << lvl;
      pref  = ((ptr >> lvl) & 1) != 0 ? lo + half : lo;
      other = ((ptr >> lvl) & 1) != 0 ? lo : lo + half;
      lo    = any_in(req, pref, half, n) ? pref : other;
    end
    return lo;
  endfunction

  task automatic model_step(
    input string tag, input int n, input int dw,
    input bit fair, input bit ext, input bit axi, input bit lockin,
    input logic [63:0] req, input logic [511:0] data, input logic gnt_in, input logic flush_in,
    input int rr_ext,
    input logic req_o, input logic [63:0] gnt_o, input logic [63:0] data_o, input int idx_o,
    input int dbg_rr, input logic dbg_lock,
    inout mstate_t st, output int win, output bit xfer);
    logic [63:0] eff, exp_gnt, exp_data, dmask;
    int ptr;
    eff = (lockin && st.lock) ? st.held : req;
    ptr = ext ? rr_ext : int'(st.ptr);
    if (eff == '0) win = 0;
    else           win = fair ? fair_pick(eff, ptr, n) : tree_pick(eff, ptr, n);
    dmask    = (64'd1 << dw) - 64'd1;
    exp_data = 64'(data >> (win * dw)) & dmask;
    exp_gnt  = (gnt_in && (axi || req[win])) ? (64'd1 << win) : 64'd0;
    chk({tag, ".req_o"},  64'(req_o), 64'(|eff));
    chk({tag, ".idx_o"},  64'(idx_o), 64'(win));
    chk({tag, ".data_o"}, data_o, exp_data);
    chk({tag, ".gnt_o"},  gnt_o, exp_gnt);
    chk({tag, ".lock"},   64'(dbg_lock), 64'(st.lock));
    if (!ext) chk({tag, ".rr"}, 64'(dbg_rr), 64'(st.ptr));
    xfer = (|eff) && gnt_in;
    if (flush_in) begin
      st = '0;
    end else begin
      if (xfer && !ext) begin
        if (fair) st.ptr = 32'(win);
        else      st.ptr = (int'(st.ptr) == n - 1) ? 32'd0 : st.ptr + 32'd1;
      end
      st.lock = lockin && (|eff) && !gnt_in;
      if (st.lock) st.held = eff;
    end
  endtask

  // One clock: check all DUTs mid-cycle, then advance past the rising edge.
  task automatic cycle();
    int wa, wb, wc, wd, we;
    bit xa, xb, xc, xd, xe;
    @(negedge clk);
    model_step("a", 8, 16, 1'b1, 1'b0, 1'b0, 1'b1, 64'(bus_a.req_i), 512'(bus_a.data_i),
               bus_a.gnt_i, flush, int'(rr_a), bus_a.req_o, 64'(bus_a.gnt_o), 64'(bus_a.data_o),
               int'(bus_a.idx_o), int'(bus_a.dbg.rr), bus_a.dbg.lock, st_a, wa, xa);
    model_step("b", 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 64'(bus_b.req_i), 512'(bus_b.data_i),
               bus_b.gnt_i, flush, int'(rr_b), bus_b.req_o, 64'(bus_b.gnt_o), 64'(bus_b.data_o),
               int'(bus_b.idx_o), int'(bus_b.dbg.rr), bus_b.dbg.lock, st_b, wb, xb);
    model_step("c", NC, DWC, 1'b1, 1'b0, 1'b0, 1'b0, 64'(bus_c.req_i), 512'(bus_c.data_i),
               bus_c.gnt_i, flush, int'(rr_c), bus_c.req_o, 64'(bus_c.gnt_o), 64'(bus_c.data_o),
               int'(bus_c.idx_o), int'(bus_c.dbg.rr), bus_c.dbg.lock, st_c, wc, xc);
    model_step("d", 5, 8, 1'b1, 1'b1, 1'b0, 1'b0, 64'(bus_d.req_i), 512'(bus_d.data_i),
               bus_d.gnt_i, flush, int'(rr_x), bus_d.req_o, 64'(bus_d.gnt_o), 64'(bus_d.data_o),
               int'(bus_d.idx_o), int'(bus_d.dbg.rr), bus_d.dbg.lock, st_d, wd, xd);
    model_step("e", 1, 8, 1'b1, 1'b0, 1'b0, 1'b1, 64'(bus_e.req_i), 512'(bus_e.data_i),
               bus_e.gnt_i, flush, int'(rr_e), bus_e.req_o, 64'(bus_e.gnt_o), 64'(bus_e.data_o),
               int'(bus_e.idx_o), int'(bus_e.dbg.rr), bus_e.dbg.lock, st_e, we, xe);
    gnt_a = 64'(bus_a.gnt_o);
    gnt_b = 64'(bus_b.gnt_o);
    gnt_c = 64'(bus_c.gnt_o);
    gnt_d = 64'(bus_d.gnt_o);
    gnt_e = 64'(bus_e.gnt_o);
    for (int k = 0; k < 8; k++) if (bus_a.gnt_o[k]) served_a[k]++;
    if (xc) begin
      n_c_xfer++;
      chk("c.sb_level", 64'(exp_q[wc].size()), 64'd1);
      if (exp_q[wc].size() > 0) chk("c.sb_data", 64'(bus_c.data_o), 64'(exp_q[wc].pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // A source keeps its request until it transfers, then re-requests with new data by chance.
  task automatic drive_src(input int n, input logic [63:0] req, input logic [63:0] gnt,
                           input int pct, output logic [63:0] nreq, output logic [63:0] fresh);
    nreq  = req;
    fresh = '0;
    for (int k = 0; k < n; k++) begin
      if (!req[k] || gnt[k]) begin
        nreq[k]  = ($urandom_range(0, 99) < pct);
        fresh[k] = nreq[k];
      end
    end
  endtask

  task automatic clear_inputs();
    bus_a.req_i = '0; bus_a.gnt_i = 1'b0;
    bus_b.req_i = '0; bus_b.gnt_i = 1'b0;
    bus_c.req_i = '0; bus_c.gnt_i = 1'b0;
    bus_d.req_i = '0; bus_d.gnt_i = 1'b0;
    bus_e.req_i = '0; bus_e.gnt_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_a.data_i[k] = 16'($urandom);
      bus_b.data_i[k] = 16'($urandom);
    end
    for (int k = 0; k < NC; k++) bus_c.data_i[k] = DWC'({$urandom, $urandom});
    for (int k = 0; k < 5; k++) bus_d.data_i[k] = 8'($urandom);
    bus_e.data_i[0] = 8'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] nr, fr;
    clear_inputs();
    st_a = '0; st_b = '0; st_c = '0; st_d = '0; st_e = '0;
    gnt_a = '0; gnt_b = '0; gnt_c = '0; gnt_d = '0; gnt_e = '0;
    for (int k = 0; k < 8; k++) served_a[k] = 0;

    // Reset held with an active transfer: pointer must stay 0, outputs still follow inputs.
    rst_n = 1'b1;
    bus_a.req_i = 8'h10;
    bus_a.gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.a_rr", 64'(bus_a.dbg.rr), 64'd0);
    chk("rst.a_lock", 64'(bus_a.dbg.lock), 64'd0);
    chk("rst.a_idx", 64'(bus_a.idx_o), 64'd4);
    chk("rst.b_rr", 64'(bus_b.dbg.rr), 64'd0);
    rst_n = 1'b0;

    // Single requester 3.
    bus_a.req_i = 8'b0000_1000;
    bus_a.data_i[3] = 16'hA5C3;
    bus_a.gnt_i = 1'b1;
    repeat (4) begin
      #1;
      chk("s1.gnt_o", 64'(bus_a.gnt_o), 64'h08);
      chk("s1.idx_o", 64'(bus_a.idx_o), 64'd3);
      chk("s1.data_o", 64'(bus_a.data_o), 64'hA5C3);
      cycle();
    end

    // Requesters 0,2,5 always active: equal share.
    for (int k = 0; k < 8; k++) served_a[k] = 0;
    bus_a.req_i = 8'b0010_0101;
    repeat (30) cycle();
    chk("s2.served0", 64'(served_a[0]), 64'd10);
    chk("s2.served2", 64'(served_a[2]), 64'd10);
    chk("s2.served5", 64'(served_a[5]), 64'd10);

    // Lock: decision held while output stalls, late requester ignored.
    bus_a.req_i = '0; bus_a.gnt_i = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus_a.req_i = 8'b0001_0010;
    repeat (3) begin
      #1;
      chk("s3.idx_stall", 64'(bus_a.idx_o), 64'd1);
      cycle();
    end
    bus_a.req_i = 8'b0101_0010;
    #1;
    chk("s3.idx_late", 64'(bus_a.idx_o), 64'd1);
    chk("s3.locked", 64'(bus_a.dbg.lock), 64'd1);
    cycle();
    bus_a.gnt_i = 1'b1;
    #1;
    chk("s3.idx_rel", 64'(bus_a.idx_o), 64'd1);
    chk("s3.gnt_rel", 64'(bus_a.gnt_o), 64'h02);
    cycle();

    // Flush while locked with pointer at 5.
    bus_a.req_i = 8'b0111_0000;
    repeat (2) cycle();
    chk("s4.rr5", 64'(bus_a.dbg.rr), 64'd5);
    bus_a.req_i = 8'b0101_0010;
    bus_a.gnt_i = 1'b0;
    cycle();
    chk("s4.lock_set", 64'(bus_a.dbg.lock), 64'd1);
    chk("s4.idx_lock", 64'(bus_a.idx_o), 64'd6);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    chk("s4.lock_clr", 64'(bus_a.dbg.lock), 64'd0);
    chk("s4.rr_clr", 64'(bus_a.dbg.rr), 64'd0);
    chk("s4.idx_restart", 64'(bus_a.idx_o), 64'd1);
    cycle();

    // No requests with output ready: plain vs AXI-style grant.
    bus_a.req_i = '0; bus_a.gnt_i = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus_b.req_i = '0; bus_b.gnt_i = 1'b1;
    #1;
    chk("s5.a_gnt_o", 64'(bus_a.gnt_o), 64'd0);
    chk("s5.a_req_o", 64'(bus_a.req_o), 64'd0);
    chk("s5.b_gnt_o", 64'(bus_b.gnt_o), 64'h01);
    chk("s5.b_req_o", 64'(bus_b.req_o), 64'd0);
    cycle();
    gnt_a = '0; gnt_b = '0;

    // Random traffic on every configuration.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drive_src(8, 64'(bus_a.req_i), gnt_a, 60, nr, fr);
      bus_a.req_i = nr[7:0];
      for (int k = 0; k < 8; k++) if (fr[k]) bus_a.data_i[k] = 16'($urandom);
      bus_a.gnt_i = ($urandom_range(0, 3) != 0);

      drive_src(8, 64'(bus_b.req_i), gnt_b, 50, nr, fr);
      bus_b.req_i = nr[7:0];
      for (int k = 0; k < 8; k++) if (fr[k]) bus_b.data_i[k] = 16'($urandom);
      bus_b.gnt_i = ($urandom_range(0, 3) != 0);

      drive_src(NC, 64'(bus_c.req_i), gnt_c, 40, nr, fr);
      bus_c.req_i = nr[NC-1:0];
      for (int k = 0; k < NC; k++) begin
        if (fr[k]) begin
          bus_c.data_i[k] = DWC'({$urandom, $urandom});
          exp_q[k].push_back(bus_c.data_i[k]);
        end
      end
      bus_c.gnt_i = ($urandom_range(0, 3) != 0);

      drive_src(5, 64'(bus_d.req_i), gnt_d, 50, nr, fr);
      bus_d.req_i = nr[4:0];
      for (int k = 0; k < 5; k++) if (fr[k]) bus_d.data_i[k] = 8'($urandom);
      bus_d.gnt_i = ($urandom_range(0, 3) != 0);
      rr_x = 3'($urandom_range(0, 4));

      drive_src(1, 64'(bus_e.req_i), gnt_e, 50, nr, fr);
      bus_e.req_i = nr[0:0];
      if (fr[0]) bus_e.data_i[0] = 8'($urandom);
      bus_e.gnt_i = ($urandom_range(0, 1) != 0);

      flush = ($urandom_range(0, 63) == 0);
      cycle();
    end
    flush = 1'b0;
    chk("c.xfers_seen", 64'(n_c_xfer > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
